// File: rtl/bank_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : bank_cmd_sequencer
// Purpose : Per-request ACT/PRE/RD/WR sequencer with 16-entry open-row table.
// Rev     : 1.0
// ============================================================================
module bank_cmd_sequencer #(
  parameter int unsigned T_RCD = 4,
  parameter int unsigned T_RP  = 4,
  parameter int unsigned T_CCD = 2
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [15:0] req_row,
  input  logic [9:0]  req_col,
  input  logic [1:0]  req_bank_group,
  input  logic [1:0]  req_bank,
  output logic        cmd_valid,
  output logic [1:0]  cmd_type,
  output logic [15:0] cmd_row,
  output logic [9:0]  cmd_col,
  output logic [1:0]  cmd_bank_group,
  output logic [1:0]  cmd_bank,
  output logic        busy
);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_PRE      = 3'd1,
    ST_WAIT_RP  = 3'd2,
    ST_ACT      = 3'd3,
    ST_WAIT_RCD = 3'd4,
    ST_COL      = 3'd5
  } state_e;

  localparam logic [1:0] CMD_ACT = 2'd0;
  localparam logic [1:0] CMD_RD  = 2'd1;
  localparam logic [1:0] CMD_WR  = 2'd2;
  localparam logic [1:0] CMD_PRE = 2'd3;

  localparam logic [3:0] RCD_LOAD = 4'(T_RCD - 1);
  localparam logic [3:0] RP_LOAD  = 4'(T_RP - 1);
  localparam logic [3:0] CCD_LOAD = 4'(T_CCD - 1);

  state_e      state_q, state_d;
  logic        we_q, we_d;
  logic [15:0] row_q, row_d;
  logic [9:0]  col_q, col_d;
  logic [1:0]  bg_q, bg_d;
  logic [1:0]  ba_q, ba_d;
  logic [3:0]  timer_q, timer_d;
  logic [3:0]  ccd_q, ccd_d;

  logic [15:0] open_q;
  logic [15:0] open_row_q [16];

  // Last-issued field values, presented while a field is not being driven
  logic [1:0]  cmd_type_q;
  logic [15:0] cmd_row_q;
  logic [9:0]  cmd_col_q;
  logic [1:0]  cmd_bg_q;
  logic [1:0]  cmd_ba_q;

  logic        accept;
  logic [3:0]  lookup_idx;
  logic [3:0]  tbl_idx;
  logic        issue;
  logic [1:0]  issue_type;
  logic        tbl_set;
  logic        tbl_clr;

  assign req_ready  = (state_q == ST_IDLE) && !sys_rst;
  assign accept     = req_valid && req_ready;
  assign lookup_idx = {req_bank_group, req_bank};
  assign tbl_idx    = {bg_q, ba_q};
  assign busy       = (state_q != ST_IDLE);

  always_comb begin
    state_d    = state_q;
    we_d       = we_q;
    row_d      = row_q;
    col_d      = col_q;
    bg_d       = bg_q;
    ba_d       = ba_q;
    timer_d    = timer_q;
    ccd_d      = (ccd_q != 4'd0) ? ccd_q - 4'd1 : 4'd0;
    issue      = 1'b0;
    issue_type = CMD_ACT;
    tbl_set    = 1'b0;
    tbl_clr    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          we_d  = req_we;
          row_d = req_row;
          col_d = req_col;
          bg_d  = req_bank_group;
          ba_d  = req_bank;
          if (open_q[lookup_idx] && (open_row_q[lookup_idx] == req_row)) begin
            state_d = ST_COL;
          end else if (open_q[lookup_idx]) begin
            state_d = ST_PRE;
          end else begin
            state_d = ST_ACT;
          end
        end
      end
      ST_PRE: begin
        issue      = 1'b1;
        issue_type = CMD_PRE;
        tbl_clr    = 1'b1;
        timer_d    = RP_LOAD;
        state_d    = (T_RP == 1) ? ST_ACT : ST_WAIT_RP;
      end
      ST_WAIT_RP: begin
        if (timer_q <= 4'd1) begin
          state_d = ST_ACT;
        end else begin
          timer_d = timer_q - 4'd1;
        end
      end
      ST_ACT: begin
        issue      = 1'b1;
        issue_type = CMD_ACT;
        tbl_set    = 1'b1;
        timer_d    = RCD_LOAD;
        state_d    = (T_RCD == 1) ? ST_COL : ST_WAIT_RCD;
      end
      ST_WAIT_RCD: begin
        if (timer_q <= 4'd1) begin
          state_d = ST_COL;
        end else begin
          timer_d = timer_q - 4'd1;
        end
      end
      ST_COL: begin
        // Column commands wait out tCCD from the previous one
        if (ccd_q == 4'd0) begin
          issue      = 1'b1;
          issue_type = we_q ? CMD_WR : CMD_RD;
          ccd_d      = CCD_LOAD;
          state_d    = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    cmd_valid      = issue;
    cmd_type       = issue ? issue_type : cmd_type_q;
    cmd_row        = (issue && issue_type == CMD_ACT) ? row_q : cmd_row_q;
    cmd_col        = (issue && (issue_type == CMD_RD || issue_type == CMD_WR)) ? col_q : cmd_col_q;
    cmd_bank_group = issue ? bg_q : cmd_bg_q;
    cmd_bank       = issue ? ba_q : cmd_ba_q;
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q    <= ST_IDLE;
      we_q       <= 1'b0;
      row_q      <= '0;
      col_q      <= '0;
      bg_q       <= '0;
      ba_q       <= '0;
      timer_q    <= '0;
      ccd_q      <= '0;
      open_q     <= '0;
      open_row_q <= '{default: '0};
      cmd_type_q <= '0;
      cmd_row_q  <= '0;
      cmd_col_q  <= '0;
      cmd_bg_q   <= '0;
      cmd_ba_q   <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      row_q   <= row_d;
      col_q   <= col_d;
      bg_q    <= bg_d;
      ba_q    <= ba_d;
      timer_q <= timer_d;
      ccd_q   <= ccd_d;
      if (issue) begin
        cmd_type_q <= cmd_type;
        cmd_row_q  <= cmd_row;
        cmd_col_q  <= cmd_col;
        cmd_bg_q   <= cmd_bank_group;
        cmd_ba_q   <= cmd_bank;
      end
      if (tbl_clr) begin
        open_q[tbl_idx] <= 1'b0;
      end
      if (tbl_set) begin
        open_q[tbl_idx]     <= 1'b1;
        open_row_q[tbl_idx] <= row_q;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bank_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : tb_bank_cmd_sequencer
// Purpose : Directed scoreboard bench for bank_cmd_sequencer (4/4/2 timing).
// Rev     : 1.0
// ============================================================================
module tb_bank_cmd_sequencer;

  localparam int T_RCD = 4;
  localparam int T_RP  = 4;

  localparam logic [1:0] ACT = 2'd0;
  localparam logic [1:0] RD  = 2'd1;
  localparam logic [1:0] WR  = 2'd2;
  localparam logic [1:0] PRE = 2'd3;

  localparam int K_HIT    = 0;
  localparam int K_CLOSED = 1;
  localparam int K_CONF   = 2;

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [15:0] req_row;
  logic [9:0]  req_col;
  logic [1:0]  req_bank_group;
  logic [1:0]  req_bank;
  logic        cmd_valid;
  logic [1:0]  cmd_type;
  logic [15:0] cmd_row;
  logic [9:0]  cmd_col;
  logic [1:0]  cmd_bank_group;
  logic [1:0]  cmd_bank;
  logic        busy;

  bank_cmd_sequencer #(.T_RCD(4), .T_RP(4), .T_CCD(2)) dut (
    .sys_clk        (sys_clk),
    .sys_rst        (sys_rst),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_we         (req_we),
    .req_row        (req_row),
    .req_col        (req_col),
    .req_bank_group (req_bank_group),
    .req_bank       (req_bank),
    .cmd_valid      (cmd_valid),
    .cmd_type       (cmd_type),
    .cmd_row        (cmd_row),
    .cmd_col        (cmd_col),
    .cmd_bank_group (cmd_bank_group),
    .cmd_bank       (cmd_bank),
    .busy           (busy)
  );

  always #5 sys_clk = ~sys_clk;

  int cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  typedef struct {
    logic [1:0]  typ;
    logic [15:0] row;
    logic [9:0]  col;
    logic [1:0]  bg;
    logic [1:0]  ba;
    int          at;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] hold_row = '0;
  logic [9:0]  hold_col = '0;
  int          errors = 0;
  int          checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Unused fields of a command keep the last driven value
  function automatic void push_cmd(input logic [1:0] t, input logic [15:0] r,
                                   input logic [9:0] c, input logic [1:0] g,
                                   input logic [1:0] b, input int at);
    exp_t e;
    if (t == ACT) hold_row = r;
    if (t == RD || t == WR) hold_col = c;
    e.typ = t; e.row = hold_row; e.col = hold_col; e.bg = g; e.ba = b; e.at = at;
    sb.push_back(e);
  endfunction

  always @(negedge sys_clk) begin
    if (cmd_valid === 1'b1) begin
      checks++;
      assert (sb.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_cmd: observed type=%0d at cycle %0d, expected no command", cmd_type, cyc);
      end
      if (sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        chk("cmd_cycle", 32'(cyc), 32'(e.at));
        chk("cmd_type", 32'(cmd_type), 32'(e.typ));
        chk("cmd_row", 32'(cmd_row), 32'(e.row));
        chk("cmd_col", 32'(cmd_col), 32'(e.col));
        chk("cmd_bank_group", 32'(cmd_bank_group), 32'(e.bg));
        chk("cmd_bank", 32'(cmd_bank), 32'(e.ba));
      end
    end
  end

  // Entered and left on a falling edge; a = cycle in which the request is accepted
  task automatic do_req(input int kind, input logic we, input logic [15:0] row,
                        input logic [9:0] col, input logic [1:0] bg, input logic [1:0] ba,
                        input bit with_col, output int a);
    int n = 0;
    logic [1:0] ct;
    while (req_ready !== 1'b1 && n < 200) begin
      @(negedge sys_clk);
      n++;
    end
    chk("ready_wait_bounded", 32'(n < 200), 32'd1);
    req_valid = 1'b1; req_we = we; req_row = row; req_col = col;
    req_bank_group = bg; req_bank = ba;
    a = cyc;
    @(posedge sys_clk);
    ct = we ? WR : RD;
    case (kind)
      K_HIT: begin
        if (with_col) push_cmd(ct, row, col, bg, ba, a + 1);
      end
      K_CLOSED: begin
        push_cmd(ACT, row, col, bg, ba, a + 1);
        if (with_col) push_cmd(ct, row, col, bg, ba, a + 1 + T_RCD);
      end
      default: begin
        push_cmd(PRE, row, col, bg, ba, a + 1);
        push_cmd(ACT, row, col, bg, ba, a + 1 + T_RP);
        if (with_col) push_cmd(ct, row, col, bg, ba, a + 1 + T_RP + T_RCD);
      end
    endcase
    @(negedge sys_clk);
    req_valid = 1'b0;
  endtask

  initial begin
    int a;
    int a1;
    int n;
    sys_rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_row = '0; req_col = '0;
    req_bank_group = '0; req_bank = '0;
    repeat (3) @(negedge sys_clk);
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_cmd_valid", 32'(cmd_valid), 32'd0);
    chk("rst_cmd_type", 32'(cmd_type), 32'd0);
    chk("rst_cmd_fields", {cmd_row, cmd_col, cmd_bank_group, cmd_bank}, 32'd0);
    sys_rst = 1'b0;
    @(negedge sys_clk);
    chk("idle_ready", 32'(req_ready), 32'd1);

    // Closed bank read, then ready returns the cycle after RD
    do_req(K_CLOSED, 1'b0, 16'h0123, 10'h010, 2'd1, 2'd2, 1'b1, a);
    while (cyc < a + 5) @(negedge sys_clk);
    chk("ready_in_col", 32'(req_ready), 32'd0);
    chk("busy_in_col", 32'(busy), 32'd1);
    @(negedge sys_clk);
    chk("ready_after_rd", 32'(req_ready), 32'd1);
    chk("busy_after_rd", 32'(busy), 32'd0);

    do_req(K_HIT, 1'b1, 16'h0123, 10'h020, 2'd1, 2'd2, 1'b1, a);
    do_req(K_CONF, 1'b0, 16'h0456, 10'h030, 2'd1, 2'd2, 1'b1, a);

    // Back-to-back hits: one IDLE cycle between column commands
    do_req(K_HIT, 1'b0, 16'h0456, 10'h040, 2'd1, 2'd2, 1'b1, a1);
    chk("b2b_busy_col1", 32'(busy), 32'd1);
    chk("b2b_ready_col1", 32'(req_ready), 32'd0);
    @(negedge sys_clk);
    chk("b2b_busy_idle", 32'(busy), 32'd0);
    chk("b2b_ready_idle", 32'(req_ready), 32'd1);
    do_req(K_HIT, 1'b1, 16'h0456, 10'h041, 2'd1, 2'd2, 1'b1, a);
    chk("b2b_accept_gap", 32'(a - a1), 32'd2);
    chk("b2b_busy_col2", 32'(busy), 32'd1);

    // Reset during WAIT_RCD abandons the request and clears the table
    do_req(K_CLOSED, 1'b0, 16'h0777, 10'h055, 2'd2, 2'd1, 1'b0, a);
    @(negedge sys_clk);
    chk("wait_rcd_busy", 32'(busy), 32'd1);
    sys_rst = 1'b1;
    @(negedge sys_clk);
    chk("midrst_ready", 32'(req_ready), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_cmd_type", 32'(cmd_type), 32'd0);
    chk("midrst_cmd_row", 32'(cmd_row), 32'd0);
    hold_row = '0;
    hold_col = '0;
    sys_rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge sys_clk);
      chk("post_rst_quiet", 32'(cmd_valid), 32'd0);
    end
    do_req(K_CLOSED, 1'b0, 16'h0777, 10'h055, 2'd2, 2'd1, 1'b1, a);
    do_req(K_CLOSED, 1'b0, 16'h0456, 10'h060, 2'd1, 2'd2, 1'b1, a);

    // Same row in another bank is still a closed-bank access
    do_req(K_CLOSED, 1'b0, 16'h0001, 10'h001, 2'd0, 2'd0, 1'b1, a);
    do_req(K_CLOSED, 1'b1, 16'h0001, 10'h002, 2'd3, 2'd3, 1'b1, a);
    do_req(K_HIT, 1'b0, 16'h0001, 10'h003, 2'd0, 2'd0, 1'b1, a);

    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge sys_clk);
      n++;
    end
    repeat (10) @(negedge sys_clk);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    chk("final_idle", 32'(busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/bank_cmd_sequencer.md
BANK_CMD_SEQUENCER -- requirements
Module: bank_cmd_sequencer

Interface
REQ-001 SHALL have parameter T_RCD, default 4: ACT-to-column-command spacing in cycles, legal range 1..15.
REQ-002 SHALL have parameter T_RP, default 4: PRE-to-ACT spacing in cycles, legal range 1..15.
REQ-003 SHALL have parameter T_CCD, default 2: minimum spacing between column commands, legal range 1..15.
REQ-004 sys_clk  in  1  single clock; all logic rising-edge.
REQ-005 sys_rst  in  1  synchronous active-high reset.
REQ-006 req_valid  in  1  decoded request present.
REQ-007 req_ready  out  1  sequencer accepts a request this cycle.
REQ-008 req_we  in  1  1 = write, 0 = read.
REQ-009 req_row  in  16  row address from address mapper.
REQ-010 req_col  in  10  column address.
REQ-011 req_bank_group  in  2  bank group.
REQ-012 req_bank  in  2  bank.
REQ-013 cmd_valid  out  1  one-cycle command strobe; the PHY always accepts, there is no backpressure.
REQ-014 cmd_type  out  2  0=ACT, 1=RD, 2=WR, 3=PRE.
REQ-015 cmd_row / cmd_col / cmd_bank_group / cmd_bank  out  16/10/2/2  command address fields.
REQ-016 busy  out  1  high whenever state is not IDLE.

Function
REQ-017 SHALL keep a 16-entry bank table indexed {bank_group,bank}; each entry holds an open bit and a 16-bit open row.
REQ-018 Handshake: a request SHALL be accepted when req_valid and req_ready are both high; the request fields SHALL be latched in that cycle.
REQ-019 req_ready SHALL equal (state==IDLE) and SHALL be 0 while sys_rst is high.
REQ-020 States SHALL be IDLE, PRE, WAIT_RP, ACT, WAIT_RCD, COL.
REQ-021 On accept, the table lookup SHALL use the incoming request in the same cycle, and the next state SHALL be:
  - COL on a hit (open and row equal);
  - PRE on a conflict (open, different row);
  - ACT when the bank is closed.
REQ-022 PRE state SHALL issue PRE for one cycle, clear the entry's open bit, then go to WAIT_RP.
REQ-023 After a PRE at cycle N, ACT SHALL issue at cycle N+T_RP.
REQ-024 ACT state SHALL issue ACT with the latched row, set the entry open with that row, then go to WAIT_RCD.
REQ-025 After an ACT at cycle N, the column command SHALL issue no earlier than cycle N+T_RCD.
REQ-026 COL state SHALL issue RD or WR (per latched req_we) when the CCD counter is 0, then return to IDLE; otherwise it SHALL hold in COL.
REQ-027 The 4-bit CCD counter:
  - SHALL load T_CCD-1 when a column command issues;
  - SHALL otherwise decrement to a floor of 0.
REQ-028 Latency from accept at cycle A, with CCD clear:
  - hit: column command at A+1;
  - closed: ACT at A+1, column command at A+1+T_RCD;
  - conflict: PRE at A+1, ACT at A+1+T_RP, column command at A+1+T_RP+T_RCD.
REQ-029 Field validity: cmd_row is meaningful for ACT; cmd_col for RD/WR; bank fields for all commands. Undriven fields SHALL hold their last value.
REQ-030 At most one command SHALL issue per cycle, and cmd_valid SHALL never be high for two consecutive cycles from the same state.
REQ-031 Other banks' entries SHALL NOT change while one bank is serviced.

Reset
REQ-032 While sys_rst is high at a clock edge, the block SHALL:
  - set state to IDLE;
  - clear all open bits;
  - zero the timers and CCD counter;
  - set cmd_valid=0, cmd_type=0, cmd_row/col/bank_group/bank=0, busy=0.
REQ-033 Reset mid-operation SHALL abandon the in-flight request without issuing any further command.

Verification (T_RCD=4, T_RP=4, T_CCD=2)
REQ-034 After reset, read row 0x0123, col 0x010, bg1, ba2 accepted at cycle A -> ACT row 0x0123 bg1 ba2 at A+1; RD col 0x010 at A+5; req_ready high at A+6.
REQ-035 Then write same bank, row 0x0123, col 0x020 -> WR col 0x020 at accept+1; no ACT or PRE issued.
REQ-036 Then read same bank, row 0x0456 -> PRE bg1 ba2 at A+1; ACT row 0x0456 at A+5; RD at A+9.
REQ-037 Two back-to-back hits, each accepted the first cycle req_ready is high -> column commands exactly 2 cycles apart; busy low only in the IDLE cycle between them.
REQ-038 sys_rst pulsed during WAIT_RCD -> cmd_valid 0 from the next cycle with no RD/WR; a repeat of the same request -> ACT issued (table cleared).
REQ-039 Open bg0 ba0 row 0x0001, then access bg3 ba3 row 0x0001 -> ACT only (bank closed); a later bg0 ba0 row 0x0001 request -> immediate column command (hit retained).
